// File: rtl/alu_iterative_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_iterative_if
//  Description : Request/result bundle between the datapath and the
//                iterative ALU (start/done handshake plus operands/result).
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_iterative_if #(
    parameter int W = 32
);
    logic         start;
    logic [3:0]   ops;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;
    logic         done;
    logic         err;

    // Requester side: datapath issuing operations
    modport master (
        output start, ops, a, b,
        input  result, zero, busy, done, err
    );

    // Executor side: the ALU itself
    modport slave (
        input  start, ops, a, b,
        output result, zero, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/alu_iterative.sv
`default_nettype none
// ============================================================================
//  Module      : alu_iterative
//  Description : Datapath ALU with start/done handshake. Logic, add/sub,
//                compare and bit-swap finish in one EXEC cycle; multiply,
//                divide and modulo iterate one bit per cycle on a shared
//                shift engine, then pass through EXEC to register results.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_iterative #(
    parameter int W = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    alu_iterative_if.slave   bus
);
    // Iteration counter runs 0..W-1
    localparam int               c_CW   = $clog2(W);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(W - 1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_EXEC = 3'd1;
    localparam logic [2:0] c_MUL  = 3'd2;
    localparam logic [2:0] c_DIV  = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_MOD = 4'b0011;
    localparam logic [3:0] c_OP_NOR = 4'b0100;
    localparam logic [3:0] c_OP_MUL = 4'b0101;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_XOR = 4'b0111;
    localparam logic [3:0] c_OP_DIV = 4'b1000;
    localparam logic [3:0] c_OP_SLT = 4'b1001;
    localparam logic [3:0] c_OP_GEZ = 4'b1011;
    localparam logic [3:0] c_OP_SWP = 4'b1100;
    localparam logic [3:0] c_OP_NOP = 4'b1101;

    logic [2:0]      r_state;
    logic [3:0]      r_ops;
    // r_a: operand A; multiplicand (shifts left) or dividend -> quotient
    logic [W-1:0]    r_a;
    // r_b: operand B; multiplier (shifts right) or fixed divisor
    logic [W-1:0]    r_b;
    // r_acc: product accumulator or partial remainder
    logic [W-1:0]    r_acc;
    logic [c_CW-1:0] r_cnt;
    logic [W-1:0]    r_result;
    logic            r_zero;
    logic            r_err;
    logic            r_busy;
    logic            r_done;

    logic [W-1:0]    w_swap;
    logic [W-1:0]    w_mul_add;
    logic [W:0]      w_rem;
    logic [W:0]      w_diff;
    logic            w_qbit;
    logic            w_b_zero;
    logic            w_div_req;
    logic [W-1:0]    w_res;
    logic            w_err;

    assign bus.result = r_result;
    assign bus.zero   = r_zero;
    assign bus.err    = r_err;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_swap
            assign w_swap[gi] = r_a[W-1-gi];
        end
    endgenerate

    assign w_b_zero  = (r_b == '0);
    assign w_div_req = ((bus.ops == c_OP_DIV) || (bus.ops == c_OP_MOD)) && (bus.b != '0);

    // One step of the shared engine: shift-add multiply and restoring divide
    always_comb begin
        w_mul_add = r_acc + (r_b[0] ? r_a : '0);
        w_rem     = {r_acc, r_a[W-1]};
        w_diff    = w_rem - {1'b0, r_b};
        w_qbit    = ~w_diff[W];
    end

    // Result selection for the EXEC writeback cycle
    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (r_ops)
            c_OP_AND: w_res = r_a & r_b;
            c_OP_OR:  w_res = r_a | r_b;
            c_OP_ADD: w_res = r_a + r_b;
            c_OP_NOR: w_res = ~(r_a | r_b);
            c_OP_SUB: w_res = r_a - r_b;
            c_OP_XOR: w_res = r_a ^ r_b;
            c_OP_MUL: w_res = r_acc;
            // Divide-by-zero skips the engine, so r_a still holds the dividend
            c_OP_MOD: begin
                w_res = w_b_zero ? r_a : r_acc;
                w_err = w_b_zero;
            end
            c_OP_DIV: begin
                w_res = w_b_zero ? '1 : r_a;
                w_err = w_b_zero;
            end
            c_OP_SLT: w_res = {{(W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            c_OP_GEZ: w_res = {{(W-1){1'b0}}, ~r_a[W-1]};
            c_OP_SWP: w_res = w_swap;
            c_OP_NOP: w_res = '0;
            default: begin
                w_res = '0;
                w_err = 1'b1;
            end
        endcase
    end

    // Control FSM, operand capture, iteration engine and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_ops    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_ops  <= bus.ops;
                        r_a    <= bus.a;
                        r_b    <= bus.b;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (bus.ops == c_OP_MUL) begin
                            r_state <= c_MUL;
                        end else if (w_div_req) begin
                            r_state <= c_DIV;
                        end else begin
                            r_state <= c_EXEC;
                        end
                    end
                end
                c_MUL: begin
                    r_acc <= w_mul_add;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    if (r_cnt == c_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_EXEC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DIV: begin
                    r_acc <= w_qbit ? w_diff[W-1:0] : w_rem[W-1:0];
                    r_a   <= {r_a[W-2:0], w_qbit};
                    if (r_cnt == c_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_EXEC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_EXEC: begin
                    r_result <= w_res;
                    r_zero   <= (w_res == '0);
                    r_err    <= w_err;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= c_DONE;
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
